pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_sat_counter.sv | 30 +++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// next-PC select codes and the register-match helper used for hazards.
package pipe_ctrl_pkg;

  localparam logic [1:0] PC_ST_BOOT  = 2'd0;
  localparam logic [1:0] PC_ST_RUN   = 2'd1;
  localparam logic [1:0] PC_ST_HOLD1 = 2'd2;
  localparam logic [1:0] PC_ST_HOLD2 = 2'd3;

  localparam logic [1:0] PC_SEL_PLUS = 2'b00;
  localparam logic [1:0] PC_SEL_ID   = 2'b01;
  localparam logic [1:0] PC_SEL_EX   = 2'b10;

  // A source operand in ID depends on the EX result; x0 never matches.
  function automatic logic src_match(input logic       valid,
                                     input logic       uses,
                                     input logic [4:0] src,
                                     input logic       we,
                                     input logic [4:0] rd);
    return valid & uses & we & (rd == src) & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: decides PC/pipeline-register enables,
// flushes and next-PC select each cycle, with a small FSM for post-reset
// flush and multi-cycle branch-operand stalls, plus stall/flush statistics.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_is_branch,
  input  logic             id_redirect,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_reg_we,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [1:0] state_q, state_d;
  logic       m_hz;
  logic       stall_hz;
  logic       stall_inc;
  logic       flush_inc;

  // Operand hazards against the EX destination. A branch compares raw
  // register-file values, so any EX producer stalls it; other consumers
  // only wait on loads (ALU results are forwarded).
  always_comb begin
    m_hz = src_match(id_valid, id_uses_rs1, id_rs1_addr, ex_reg_we, ex_rd_addr)
         | src_match(id_valid, id_uses_rs2, id_rs2_addr, ex_reg_we, ex_rd_addr);
    stall_hz = m_hz & (ex_is_load | id_is_branch);
  end

  // Control outputs and next state, in priority order.
  always_comb begin
    pc_we       = 1'b1;
    pc_sel      = PC_SEL_PLUS;
    if_id_we    = 1'b1;
    id_ex_we    = 1'b1;
    ex_mem_we   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    flush_inc   = 1'b0;
    state_d     = state_q;

    if (rst || (state_q == PC_ST_BOOT)) begin
      // Flush both front registers while the PC sits at the reset vector.
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_mem_we   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = PC_ST_RUN;
    end else if (mem_busy) begin
      // Whole pipe frozen; a pending redirect keeps its inputs and waits.
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (ex_redirect) begin
      // EX target beats any ID redirect and cancels any remaining hold.
      pc_sel      = PC_SEL_EX;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b1;
      state_d     = PC_ST_RUN;
    end else if ((state_q == PC_ST_HOLD1) || (state_q == PC_ST_HOLD2)) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = (state_q == PC_ST_HOLD2) ? PC_ST_HOLD1 : PC_ST_RUN;
    end else if (stall_hz) begin
      // Load feeding a branch needs a second bubble: the value is still in MEM.
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = (id_is_branch && ex_is_load) ? PC_ST_HOLD1 : PC_ST_RUN;
    end else if (id_redirect) begin
      pc_sel      = PC_SEL_ID;
      if_id_flush = 1'b1;
      flush_inc   = 1'b1;
    end
  end

  // Stall cycles are counted outside reset/BOOT, including memory freezes.
  assign stall_inc = ~rst & (state_q != PC_ST_BOOT) & ~pc_we;

  // FSM state register; reset lands in BOOT even from a hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .inc_i (flush_inc),
    .cnt_o (flush_count)
  );

endmodule
